axi_dma_rd_sched: RTL and testbench
===================================

AXI_DMA_RD_SCHED -- requirements
Module: axi_dma_rd_sched

Round-robin scheduler that shares one DMA read-descriptor port among PORTS requesters, tags each issued descriptor with its requester index, limits outstanding descriptors and routes completion status back to the requester.

Interface
REQ-001 SHALL have parameter PORTS, default 4, number of requesters (power of 2, 2..16).
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 16, descriptor address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 20, descriptor length width.
REQ-004 SHALL have parameter TAG_WIDTH, default 8, DMA tag width; PB = clog2(PORTS); user tag width UTW = TAG_WIDTH-PB.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 8, limit on issued-but-uncompleted descriptors (1..255).
REQ-006 SHALL have port clk, input, 1: single clock, all logic rising-edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port enable, input, 1: high permits new grants.
REQ-009 SHALL have port s_req_addr, input, PORTS*AXI_ADDR_WIDTH: per-port address, port i at slice i.
REQ-010 SHALL have port s_req_len, input, PORTS*LEN_WIDTH: per-port length.
REQ-011 SHALL have port s_req_tag, input, PORTS*UTW: per-port user tag.
REQ-012 SHALL have port s_req_valid, input, PORTS: per-port request valid.
REQ-013 SHALL have port s_req_ready, output, PORTS: per-port request accept.
REQ-014 SHALL have ports m_desc_addr, m_desc_len and m_desc_tag, outputs, AXI_ADDR_WIDTH, LEN_WIDTH and TAG_WIDTH: the descriptor driven to the DMA.
REQ-015 SHALL have port m_desc_valid, output, 1, and m_desc_ready, input, 1: descriptor handshake.
REQ-016 SHALL have ports s_status_tag, input, TAG_WIDTH; s_status_error, input, 4; s_status_valid, input, 1: DMA completion status, which has no backpressure.
REQ-017 SHALL have ports m_done_valid, output, PORTS, one-hot; m_done_tag, output, UTW; m_done_error, output, 4: completion routed to the requester.
REQ-018 SHALL have port outstanding, output, 8: current count of outstanding descriptors.
REQ-019 SHALL have port status_underflow, output, 1: sticky flag for status received while outstanding==0.

Function
REQ-020 SHALL have two states: IDLE and ISSUE.
REQ-021 IDLE: SHALL grant when enable=1, at least one s_req_valid is set and outstanding<MAX_OUTSTANDING.
- Grant goes to the first valid port at or after rr_ptr, wrapping modulo PORTS.
- On grant, the block SHALL pulse s_req_ready[g] that same cycle.
- It SHALL register addr and len into the m_desc_* outputs and set m_desc_tag={g[PB-1:0], s_req_tag[g]}.
- It SHALL then move to ISSUE.
REQ-022 ISSUE: SHALL hold m_desc_valid=1 with stable fields until m_desc_ready=1.
- On that handshake: outstanding SHALL increment, rr_ptr SHALL become (g+1) mod PORTS, and the state SHALL return to IDLE.
- Throughput is at most one descriptor per 2 cycles.
REQ-023 s_req_ready SHALL be 0 for every port outside a grant cycle; at most one bit SHALL be set per cycle.
REQ-024 Deasserting enable SHALL block new grants only; a descriptor already in ISSUE SHALL complete, and status SHALL continue to be routed.
REQ-025 On s_status_valid, the next cycle SHALL show m_done_valid[s_status_tag[TAG_WIDTH-1:UTW]]=1 for one cycle, with m_done_tag=s_status_tag[UTW-1:0] and m_done_error=s_status_error (1-cycle latency).
REQ-026 On s_status_valid with outstanding>0, outstanding SHALL decrement.
REQ-027 When an issue handshake and s_status_valid occur in the same cycle, outstanding SHALL be unchanged.
REQ-028 On s_status_valid with outstanding==0:
- outstanding SHALL stay 0;
- status_underflow SHALL set and remain set until reset;
- the status SHALL still be routed.
REQ-029 The grant check SHALL use the registered outstanding value, so it is never exceeded; outstanding SHALL not exceed MAX_OUTSTANDING.
REQ-030 Zero-length requests SHALL be forwarded unchanged; the DMA handles them.

Reset
REQ-031 While rst_n=0, the following SHALL be cleared asynchronously: state=IDLE, rr_ptr=0, outstanding=0, status_underflow=0, m_desc_valid=0, m_desc_addr/len/tag=0, s_req_ready=0, m_done_valid=0, m_done_tag=0, m_done_error=0.
REQ-032 Reset asserted during ISSUE SHALL drop the in-flight descriptor without a done pulse; requesters SHALL re-present their requests after reset.

Verification
REQ-033 All 4 ports valid continuously, m_desc_ready=1 -> grants in order 0,1,2,3,0; m_desc_tag upper 2 bits follow that order; one descriptor every 2 cycles.
REQ-034 MAX_OUTSTANDING=2, no status returned -> exactly 2 descriptors issued, then s_req_ready=0; one status returned -> a third descriptor issued.
REQ-035 Port 2 tag 6'h15, status tag 8'h95 with error 4'h3 -> next cycle m_done_valid=4'b0100, m_done_tag=6'h15, m_done_error=4'h3.
REQ-036 Issue handshake and status in the same cycle with outstanding=3 -> outstanding stays 3.
REQ-037 Status while outstanding=0 -> status_underflow=1 and stays 1; outstanding=0.
REQ-038 m_desc_ready held low for 5 cycles, then rst_n pulsed low mid-ISSUE -> m_desc_valid drops immediately (asynchronous); all outputs return to 0.

Source files
------------

// File: rtl/axi_dma_rd_sched_if.sv
// Bus bundle for the DMA read-descriptor scheduler: request ports, descriptor
// port, completion status input, routed completions and scheduler status.
interface axi_dma_rd_sched_if #(
  parameter int PORTS          = 4,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int LEN_WIDTH      = 20,
  parameter int TAG_WIDTH      = 8
);
  localparam int PB  = $clog2(PORTS);
  localparam int UTW = TAG_WIDTH - PB;

  logic                            enable;
  logic [PORTS*AXI_ADDR_WIDTH-1:0] s_req_addr;
  logic [PORTS*LEN_WIDTH-1:0]      s_req_len;
  logic [PORTS*UTW-1:0]            s_req_tag;
  logic [PORTS-1:0]                s_req_valid;
  logic [PORTS-1:0]                s_req_ready;
  logic [AXI_ADDR_WIDTH-1:0]       m_desc_addr;
  logic [LEN_WIDTH-1:0]            m_desc_len;
  logic [TAG_WIDTH-1:0]            m_desc_tag;
  logic                            m_desc_valid;
  logic                            m_desc_ready;
  logic [TAG_WIDTH-1:0]            s_status_tag;
  logic [3:0]                      s_status_error;
  logic                            s_status_valid;
  logic [PORTS-1:0]                m_done_valid;
  logic [UTW-1:0]                  m_done_tag;
  logic [3:0]                      m_done_error;
  logic [7:0]                      outstanding;
  logic                            status_underflow;

  modport master (
    input  enable, s_req_addr, s_req_len, s_req_tag, s_req_valid,
    output s_req_ready,
    output m_desc_addr, m_desc_len, m_desc_tag, m_desc_valid,
    input  m_desc_ready,
    input  s_status_tag, s_status_error, s_status_valid,
    output m_done_valid, m_done_tag, m_done_error,
    output outstanding, status_underflow
  );

  modport slave (
    output enable, s_req_addr, s_req_len, s_req_tag, s_req_valid,
    input  s_req_ready,
    input  m_desc_addr, m_desc_len, m_desc_tag, m_desc_valid,
    output m_desc_ready,
    output s_status_tag, s_status_error, s_status_valid,
    input  m_done_valid, m_done_tag, m_done_error,
    input  outstanding, status_underflow
  );
endinterface

// File: rtl/axi_dma_rd_sched.sv
// Round-robin scheduler sharing one DMA read-descriptor port among PORTS
// requesters, with an outstanding-descriptor limit and completion routing.
module axi_dma_rd_sched #(
  parameter int PORTS           = 4,
  parameter int AXI_ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH       = 20,
  parameter int TAG_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic                clk,
  input logic                rst_n,
  axi_dma_rd_sched_if.master bus
);
  localparam int PB  = $clog2(PORTS);
  localparam int UTW = TAG_WIDTH - PB;
  localparam logic [7:0]       MAX_OUT  = 8'(MAX_OUTSTANDING);
  localparam logic [PORTS-1:0] ONE_HOT0 = {{(PORTS-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                    state_r, state_s;
  logic [PB-1:0]             rr_ptr_r, grant_port_r, pick_s;
  logic                      pick_found_s, grant_s, issue_hs_s;
  logic [7:0]                outstanding_r;
  logic                      underflow_r;
  logic [AXI_ADDR_WIDTH-1:0] desc_addr_r;
  logic [LEN_WIDTH-1:0]      desc_len_r;
  logic [TAG_WIDTH-1:0]      desc_tag_r;
  logic                      desc_valid_r;
  logic [PORTS-1:0]          done_valid_r;
  logic [UTW-1:0]            done_tag_r;
  logic [3:0]                done_error_r;

  // First valid requester at or after rr_ptr, wrapping modulo PORTS
  always_comb begin : rr_search
    logic [PB-1:0] idx_v;
    pick_s       = rr_ptr_r;
    pick_found_s = 1'b0;
    idx_v        = rr_ptr_r;
    for (int k = 0; k < PORTS; k++) begin
      idx_v = rr_ptr_r + PB'(k);
      if (!pick_found_s && bus.s_req_valid[idx_v]) begin
        pick_s       = idx_v;
        pick_found_s = 1'b1;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Next-state and grant/handshake decode
  always_comb begin
    state_s    = state_r;
    grant_s    = 1'b0;
    issue_hs_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.enable && pick_found_s && (outstanding_r < MAX_OUT)) begin
          grant_s = 1'b1;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (bus.m_desc_ready) begin
          issue_hs_s = 1'b1;
          state_s    = IDLE;
        end else begin
          state_s = ISSUE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Descriptor capture on grant, release on handshake, pointer advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      desc_addr_r  <= '0;
      desc_len_r   <= '0;
      desc_tag_r   <= '0;
      desc_valid_r <= 1'b0;
      grant_port_r <= '0;
      rr_ptr_r     <= '0;
    end else if (grant_s) begin
      desc_addr_r  <= bus.s_req_addr[pick_s*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      desc_len_r   <= bus.s_req_len[pick_s*LEN_WIDTH +: LEN_WIDTH];
      desc_tag_r   <= {pick_s, bus.s_req_tag[pick_s*UTW +: UTW]};
      desc_valid_r <= 1'b1;
      grant_port_r <= pick_s;
    end else if (issue_hs_s) begin
      desc_valid_r <= 1'b0;
      rr_ptr_r     <= grant_port_r + PB'(1'b1);
    end else begin
      desc_valid_r <= desc_valid_r;
    end
  end

  // Outstanding count; a status with nothing outstanding only flags underflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_r <= 8'd0;
      underflow_r   <= 1'b0;
    end else begin
      if (issue_hs_s && bus.s_status_valid) begin
        outstanding_r <= outstanding_r;
      end else if (issue_hs_s) begin
        outstanding_r <= outstanding_r + 8'd1;
      end else if (bus.s_status_valid && (outstanding_r != 8'd0)) begin
        outstanding_r <= outstanding_r - 8'd1;
      end else begin
        outstanding_r <= outstanding_r;
      end
      if (bus.s_status_valid && (outstanding_r == 8'd0)) begin
        underflow_r <= 1'b1;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  // Completion routing: upper tag bits select the requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_valid_r <= '0;
      done_tag_r   <= '0;
      done_error_r <= 4'h0;
    end else if (bus.s_status_valid) begin
      done_valid_r <= ONE_HOT0 << bus.s_status_tag[TAG_WIDTH-1 -: PB];
      done_tag_r   <= bus.s_status_tag[UTW-1:0];
      done_error_r <= bus.s_status_error;
    end else begin
      done_valid_r <= '0;
    end
  end

  assign bus.s_req_ready      = (grant_s && rst_n) ? (ONE_HOT0 << pick_s) : '0;
  assign bus.m_desc_addr      = desc_addr_r;
  assign bus.m_desc_len       = desc_len_r;
  assign bus.m_desc_tag       = desc_tag_r;
  assign bus.m_desc_valid     = desc_valid_r;
  assign bus.m_done_valid     = done_valid_r;
  assign bus.m_done_tag       = done_tag_r;
  assign bus.m_done_error     = done_error_r;
  assign bus.outstanding      = outstanding_r;
  assign bus.status_underflow = underflow_r;
endmodule

// File: tb/tb_axi_dma_rd_sched.sv
// Directed bench for axi_dma_rd_sched: one DUT with the default limit and a
// second limited to two outstanding descriptors.
module tb_axi_dma_rd_sched;
  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  axi_dma_rd_sched_if #(.PORTS(4), .AXI_ADDR_WIDTH(16), .LEN_WIDTH(20), .TAG_WIDTH(8)) bus ();
  axi_dma_rd_sched_if #(.PORTS(4), .AXI_ADDR_WIDTH(16), .LEN_WIDTH(20), .TAG_WIDTH(8)) bus2 ();

  axi_dma_rd_sched #(.PORTS(4), .AXI_ADDR_WIDTH(16), .LEN_WIDTH(20), .TAG_WIDTH(8),
                     .MAX_OUTSTANDING(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  axi_dma_rd_sched #(.PORTS(4), .AXI_ADDR_WIDTH(16), .LEN_WIDTH(20), .TAG_WIDTH(8),
                     .MAX_OUTSTANDING(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic send_status(input logic [7:0] tag, input logic [3:0] err);
    @(negedge clk); #1;
    bus.s_status_tag   = tag;
    bus.s_status_error = err;
    bus.s_status_valid = 1'b1;
    @(negedge clk); #1;
    bus.s_status_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.enable = 1'b0;  bus.s_req_addr = '0;  bus.s_req_len = '0;  bus.s_req_tag = '0;
    bus.s_req_valid = '0;  bus.m_desc_ready = 1'b0;  bus.s_status_tag = '0;
    bus.s_status_error = 4'h0;  bus.s_status_valid = 1'b0;
    bus2.enable = 1'b0;  bus2.s_req_addr = '0;  bus2.s_req_len = '0;  bus2.s_req_tag = '0;
    bus2.s_req_valid = '0;  bus2.m_desc_ready = 1'b0;  bus2.s_status_tag = '0;
    bus2.s_status_error = 4'h0;  bus2.s_status_valid = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({bus.m_desc_valid, bus.m_desc_addr, bus.m_desc_len, bus.m_desc_tag} !== 45'd0) begin
      n_fail++; $display("FAIL reset_desc got %b/%h/%h/%h exp 0", bus.m_desc_valid,
                         bus.m_desc_addr, bus.m_desc_len, bus.m_desc_tag);
    end
    n_tests++;
    if ({bus.m_done_valid, bus.m_done_tag, bus.m_done_error, bus.outstanding,
         bus.status_underflow, bus.s_req_ready} !== 27'd0) begin
      n_fail++; $display("FAIL reset_status got done=%b out=%0d uf=%b rdy=%b exp 0",
                         bus.m_done_valid, bus.outstanding, bus.status_underflow, bus.s_req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_tests++;
    if (bus.outstanding !== 8'd0 || bus.m_desc_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset got out=%0d valid=%b exp 0/0", bus.outstanding, bus.m_desc_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  p;
    logic [3:0]  exp_ready;
    logic [5:0]  ut;
    logic [7:0]  exp_tag;
    logic [15:0] exp_addr;
    bus.enable = 1'b1;
    bus.m_desc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.s_req_addr[i*16 +: 16] = 16'h1000 + 16'(i*256);
      bus.s_req_len[i*20 +: 20]  = 20'h00010 + 20'(i);
      bus.s_req_tag[i*6 +: 6]    = 6'h20 + 6'(i);
    end
    bus.s_req_valid = 4'b1111;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      p = 2'(j/2);
      if (j % 2 == 0) begin
        exp_ready = 4'b0001 << p;
        n_tests++;
        if (bus.s_req_ready !== exp_ready || bus.m_desc_valid !== 1'b0) begin
          n_fail++; $display("FAIL rr_grant j=%0d got ready=%b valid=%b exp ready=%b valid=0",
                             j, bus.s_req_ready, bus.m_desc_valid, exp_ready);
        end
      end else begin
        ut       = 6'h20 + {4'h0, p};
        exp_tag  = {p, ut};
        exp_addr = 16'h1000 + {6'h00, p, 8'h00};
        n_tests++;
        if (bus.m_desc_valid !== 1'b1 || bus.s_req_ready !== 4'b0000 ||
            bus.m_desc_tag !== exp_tag || bus.m_desc_addr !== exp_addr ||
            bus.m_desc_len !== 20'h00010 + {18'h0, p}) begin
          n_fail++; $display("FAIL rr_desc j=%0d got v=%b rdy=%b tag=%h addr=%h len=%h exp v=1 tag=%h addr=%h",
                             j, bus.m_desc_valid, bus.s_req_ready, bus.m_desc_tag,
                             bus.m_desc_addr, bus.m_desc_len, exp_tag, exp_addr);
        end
      end
    end
    bus.s_req_valid = 4'b0000;
    @(negedge clk); #1;
    n_tests++;
    if (bus.outstanding !== 8'd5 || bus.m_desc_valid !== 1'b0 || bus.s_req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL rr_outstanding got %0d valid=%b exp 5 valid=0", bus.outstanding, bus.m_desc_valid);
    end
  endtask

  task automatic test_status_routing();
    bus.s_req_tag[12 +: 6] = 6'h15;
    bus.s_req_valid = 4'b0100;
    #1;
    n_tests++;
    if (bus.s_req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL p2_grant got %b exp 0100", bus.s_req_ready);
    end
    @(negedge clk); #1;
    bus.s_req_valid = 4'b0000;
    n_tests++;
    if (bus.m_desc_valid !== 1'b1 || bus.m_desc_tag !== 8'h95) begin
      n_fail++; $display("FAIL p2_tag got v=%b tag=%h exp v=1 tag=95", bus.m_desc_valid, bus.m_desc_tag);
    end
    send_status(8'h95, 4'h3);
    n_tests++;
    if (bus.m_done_valid !== 4'b0100 || bus.m_done_tag !== 6'h15 || bus.m_done_error !== 4'h3) begin
      n_fail++; $display("FAIL done_route got v=%b tag=%h err=%h exp 0100/15/3",
                         bus.m_done_valid, bus.m_done_tag, bus.m_done_error);
    end
    n_tests++;
    if (bus.outstanding !== 8'd5) begin
      n_fail++; $display("FAIL status_dec got %0d exp 5", bus.outstanding);
    end
    @(negedge clk); #1;
    n_tests++;
    if (bus.m_done_valid !== 4'b0000) begin
      n_fail++; $display("FAIL done_pulse got %b exp 0000", bus.m_done_valid);
    end
  endtask

  task automatic test_simultaneous();
    send_status(8'h00, 4'h0);
    send_status(8'h00, 4'h0);
    n_tests++;
    if (bus.outstanding !== 8'd3) begin
      n_fail++; $display("FAIL drain_to_3 got %0d exp 3", bus.outstanding);
    end
    bus.m_desc_ready = 1'b0;
    bus.s_req_valid = 4'b0001;
    @(negedge clk); #1;
    bus.s_req_valid = 4'b0000;
    n_tests++;
    if (bus.m_desc_valid !== 1'b1 || bus.m_desc_tag[7:6] !== 2'b00) begin
      n_fail++; $display("FAIL wrap_grant got v=%b port=%0d exp v=1 port=0", bus.m_desc_valid, bus.m_desc_tag[7:6]);
    end
    bus.m_desc_ready = 1'b1;
    bus.s_status_tag = 8'h40;  bus.s_status_error = 4'hA;  bus.s_status_valid = 1'b1;
    @(negedge clk); #1;
    bus.s_status_valid = 1'b0;
    n_tests++;
    if (bus.outstanding !== 8'd3 || bus.m_desc_valid !== 1'b0) begin
      n_fail++; $display("FAIL simul_hold got out=%0d v=%b exp 3/0", bus.outstanding, bus.m_desc_valid);
    end
    n_tests++;
    if (bus.m_done_valid !== 4'b0010 || bus.m_done_error !== 4'hA) begin
      n_fail++; $display("FAIL simul_done got %b/%h exp 0010/a", bus.m_done_valid, bus.m_done_error);
    end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 3; i++) send_status(8'hC0, 4'h0);
    n_tests++;
    if (bus.outstanding !== 8'd0 || bus.status_underflow !== 1'b0) begin
      n_fail++; $display("FAIL drain_to_0 got out=%0d uf=%b exp 0/0", bus.outstanding, bus.status_underflow);
    end
    send_status(8'h7F, 4'hF);
    n_tests++;
    if (bus.status_underflow !== 1'b1 || bus.outstanding !== 8'd0 ||
        bus.m_done_valid !== 4'b0010 || bus.m_done_tag !== 6'h3F) begin
      n_fail++; $display("FAIL underflow got uf=%b out=%0d done=%b tag=%h exp 1/0/0010/3f",
                         bus.status_underflow, bus.outstanding, bus.m_done_valid, bus.m_done_tag);
    end
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (bus.status_underflow !== 1'b1 || bus.outstanding !== 8'd0) begin
      n_fail++; $display("FAIL underflow_sticky got uf=%b out=%0d exp 1/0", bus.status_underflow, bus.outstanding);
    end
  endtask

  task automatic test_enable();
    bus.enable = 1'b0;
    bus.s_req_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if (bus.s_req_ready !== 4'b0000 || bus.m_desc_valid !== 1'b0) begin
        n_fail++; $display("FAIL enable_block i=%0d got rdy=%b v=%b exp 0000/0", i, bus.s_req_ready, bus.m_desc_valid);
      end
    end
    bus.enable = 1'b1;
    #1;
    n_tests++;
    if (bus.s_req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL enable_grant got %b exp 0010", bus.s_req_ready);
    end
    @(negedge clk); #1;
    bus.s_req_valid = 4'b0000;
    bus.enable = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (bus.m_desc_valid !== 1'b0 || bus.outstanding !== 8'd1) begin
      n_fail++; $display("FAIL enable_drain got v=%b out=%0d exp 0/1", bus.m_desc_valid, bus.outstanding);
    end
    bus.enable = 1'b1;
  endtask

  task automatic test_max_outstanding();
    int grants;
    grants = 0;
    bus2.enable = 1'b1;
    bus2.m_desc_ready = 1'b1;
    bus2.s_req_valid = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      if (bus2.s_req_ready !== 4'b0000) grants++;
    end
    n_tests++;
    if (grants != 2 || bus2.outstanding !== 8'd2 || bus2.s_req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL max_limit got grants=%0d out=%0d rdy=%b exp 2/2/0000",
                         grants, bus2.outstanding, bus2.s_req_ready);
    end
    bus2.s_status_tag = 8'h00;  bus2.s_status_error = 4'h0;  bus2.s_status_valid = 1'b1;
    @(negedge clk); #1;
    bus2.s_status_valid = 1'b0;
    n_tests++;
    if (bus2.s_req_ready !== 4'b0100 || bus2.outstanding !== 8'd1) begin
      n_fail++; $display("FAIL max_resume got rdy=%b out=%0d exp 0100/1", bus2.s_req_ready, bus2.outstanding);
    end
    @(negedge clk); #1;
    bus2.s_req_valid = 4'b0000;
    n_tests++;
    if (bus2.m_desc_valid !== 1'b1 || bus2.m_desc_tag[7:6] !== 2'b10) begin
      n_fail++; $display("FAIL max_third got v=%b port=%0d exp 1/2", bus2.m_desc_valid, bus2.m_desc_tag[7:6]);
    end
    @(negedge clk); #1;
    n_tests++;
    if (bus2.outstanding !== 8'd2) begin
      n_fail++; $display("FAIL max_count got %0d exp 2", bus2.outstanding);
    end
  endtask

  task automatic test_reset_mid_issue();
    bus.m_desc_ready = 1'b0;
    bus.s_req_addr[48 +: 16] = 16'hBEEF;
    bus.s_req_valid = 4'b1000;
    @(negedge clk); #1;
    bus.s_req_valid = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if (bus.m_desc_valid !== 1'b1 || bus.m_desc_addr !== 16'hBEEF) begin
        n_fail++; $display("FAIL issue_hold i=%0d got v=%b addr=%h exp 1/beef", i, bus.m_desc_valid, bus.m_desc_addr);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.m_desc_valid, bus.m_desc_addr, bus.m_desc_len, bus.m_desc_tag} !== 45'd0) begin
      n_fail++; $display("FAIL async_rst_desc got v=%b addr=%h tag=%h exp 0", bus.m_desc_valid,
                         bus.m_desc_addr, bus.m_desc_tag);
    end
    n_tests++;
    if (bus.outstanding !== 8'd0 || bus.status_underflow !== 1'b0 || bus.m_done_valid !== 4'b0000 ||
        bus.s_req_ready !== 4'b0000 || bus2.outstanding !== 8'd0) begin
      n_fail++; $display("FAIL async_rst_status got out=%0d uf=%b done=%b out2=%0d exp 0",
                         bus.outstanding, bus.status_underflow, bus.m_done_valid, bus2.outstanding);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_tests++;
    if (bus.m_desc_valid !== 1'b0 || bus.m_done_valid !== 4'b0000) begin
      n_fail++; $display("FAIL after_rst got v=%b done=%b exp 0/0000", bus.m_desc_valid, bus.m_done_valid);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_status_routing();
    test_simultaneous();
    test_underflow();
    test_enable();
    test_max_outstanding();
    test_reset_mid_issue();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
